// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the WISC ISA: FETCH/DECODE/EXEC/MEM/WB with
// registered control strobes, a bounded memory handshake and sticky HALT/ERR states.
module mc_ctrl_fsm #(
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [4:0]         opcode,
    input  logic [1:0]         func,
    input  logic               mem_done,
    output logic               instr_ready,
    output logic [ALUOP_W-1:0] aluop,
    output logic               regwrite,
    output logic               memread,
    output logic               memwrite,
    output logic               pc_en,
    output logic               halt,
    output logic               err,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_opcode;
    logic [1:0]         r_func;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_timeout;
    logic               w_is_halt;
    logic               w_is_nop;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_wb_en;
    logic [ALUOP_W-1:0] r_aluop;
    logic [ALUOP_W-1:0] w_aluop_nxt;
    logic               r_regwrite, w_regwrite_nxt;
    logic               r_memread,  w_memread_nxt;
    logic               r_memwrite, w_memwrite_nxt;
    logic               r_pc_en,    w_pc_en_nxt;
    logic               r_halt,     w_halt_nxt;
    logic               r_err,      w_err_nxt;
    logic               r_busy,     w_busy_nxt;

    // Register-register ops pick the operation from func, immediate shifts from opcode[1:0].
    function automatic logic [2:0] decode_aluop(input logic [4:0] op, input logic [1:0] fn);
        logic [2:0] res;
        case (op)
            5'b11011:                               res = {1'b1, fn};
            5'b11010:                               res = {1'b0, fn};
            5'b10100, 5'b10101, 5'b10110, 5'b10111: res = {1'b0, op[1:0]};
            default:                                res = 3'b100;
        endcase
        return res;
    endfunction

    assign w_is_halt  = (r_opcode == 5'b00000);
    assign w_is_nop   = (r_opcode == 5'b00001);
    assign w_is_load  = (r_opcode == 5'b10001);
    assign w_is_store = (r_opcode == 5'b10000) || (r_opcode == 5'b10011);
    assign w_wb_en    = !(w_is_halt || w_is_nop || (r_opcode[4:2] == 3'b011) ||
                          (r_opcode == 5'b00100) || (r_opcode == 5'b00101) ||
                          (r_opcode == 5'b10000));

    assign instr_ready = (r_state == S_FETCH);
    assign aluop       = r_aluop;
    assign regwrite    = r_regwrite;
    assign memread     = r_memread;
    assign memwrite    = r_memwrite;
    assign pc_en       = r_pc_en;
    assign halt        = r_halt;
    assign err         = r_err;
    assign busy        = r_busy;

    // Saturating wait-counter increment and timeout detect.
    always_comb begin
        if (r_cnt == CNT_W'(TIMEOUT)) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));
    end

    // State register and MEM wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_MEM) begin
                r_cnt <= w_cnt_inc;
            end else if (r_state == S_WB) begin
                r_cnt <= {CNT_W{1'b0}};
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Instruction latch; opcode and func are only looked at on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opcode <= 5'b00000;
            r_func   <= 2'b00;
        end else if ((r_state == S_FETCH) && instr_valid) begin
            r_opcode <= opcode;
            r_func   <= func;
        end else begin
            r_opcode <= r_opcode;
            r_func   <= r_func;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (instr_valid) w_state_nxt = S_DECODE;
                else             w_state_nxt = S_FETCH;
            end
            S_DECODE: begin
                if (w_is_halt)     w_state_nxt = S_HALT;
                else if (w_is_nop) w_state_nxt = S_WB;
                else               w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_is_load || w_is_store) w_state_nxt = S_MEM;
                else                         w_state_nxt = S_WB;
            end
            // mem_done takes priority over a timeout in the same cycle.
            S_MEM: begin
                if (mem_done)       w_state_nxt = S_WB;
                else if (w_timeout) w_state_nxt = S_ERR;
                else                w_state_nxt = S_MEM;
            end
            S_WB:    w_state_nxt = S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_ERR;
        endcase
    end

    // Output decode from the next state, so registered strobes line up with their state.
    always_comb begin
        w_busy_nxt     = (w_state_nxt == S_DECODE) || (w_state_nxt == S_EXEC) ||
                         (w_state_nxt == S_MEM)    || (w_state_nxt == S_WB);
        w_memread_nxt  = (w_state_nxt == S_MEM) && w_is_load;
        w_memwrite_nxt = (w_state_nxt == S_MEM) && w_is_store;
        w_pc_en_nxt    = (w_state_nxt == S_WB);
        w_regwrite_nxt = (w_state_nxt == S_WB) && w_wb_en;
        w_halt_nxt     = (w_state_nxt == S_HALT);
        w_err_nxt      = (w_state_nxt == S_ERR);
        if (r_state == S_DECODE) begin
            w_aluop_nxt = ALUOP_W'(decode_aluop(r_opcode, r_func));
        end else begin
            w_aluop_nxt = r_aluop;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aluop    <= {ALUOP_W{1'b0}};
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_pc_en    <= 1'b0;
            r_halt     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_aluop    <= w_aluop_nxt;
            r_regwrite <= w_regwrite_nxt;
            r_memread  <= w_memread_nxt;
            r_memwrite <= w_memwrite_nxt;
            r_pc_en    <= w_pc_en_nxt;
            r_halt     <= w_halt_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus queues expected retire/halt/error events
// from an instruction-level model; a negedge monitor matches them as the DUT produces them.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;

    localparam int TIMEOUT = 15;
    localparam int K_RET   = 0;
    localparam int K_HALT  = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int kind;
        int lat;
        int aluop;
        int rw;
        int rd;
        int wr;
    } exp_t;

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       instr_valid = 1'b0;
    logic [4:0] opcode      = 5'b00000;
    logic [1:0] func        = 2'b00;
    logic       mem_done    = 1'b0;
    logic       instr_ready;
    logic [2:0] aluop;
    logic       regwrite, memread, memwrite, pc_en, halt, err, busy;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_d = 0;

    int   cyc = 0, acc_cyc = 0, rd_cnt = 0, wr_cnt = 0, mcnt = 0;
    logic prev_halt = 1'b0, prev_err = 1'b0;

    mc_ctrl_fsm #(.ALUOP_W(3), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .func(func),
        .mem_done(mem_done), .instr_ready(instr_ready), .aluop(aluop), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .pc_en(pc_en), .halt(halt), .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction-level model: class rules and latencies counted in cycles after acceptance.
    function automatic exp_t model(input logic [4:0] op, input logic [1:0] f, input int d);
        exp_t e;
        int   opn, n;
        bit   ld, st, wb;
        opn = int'(op);
        ld  = (opn == 17);
        st  = (opn == 16) || (opn == 19);
        wb  = !(opn <= 1 || (opn >= 12 && opn <= 15) || opn == 4 || opn == 5 || opn == 16);
        if (opn == 27)                    e.aluop = 4 + int'(f);
        else if (opn == 26)               e.aluop = int'(f);
        else if (opn >= 20 && opn <= 23)  e.aluop = opn - 20;
        else                              e.aluop = 4;
        e.rw = wb ? 1 : 0;
        e.rd = 0;
        e.wr = 0;
        if (opn == 0) begin
            e.kind = K_HALT; e.lat = 2; e.rw = 0;
        end else if (ld || st) begin
            n = (d >= 1 && d <= TIMEOUT) ? d : TIMEOUT;
            e.kind = (d >= 1 && d <= TIMEOUT) ? K_RET : K_ERR;
            e.lat  = 3 + n;
            e.rd   = ld ? n : 0;
            e.wr   = st ? n : 0;
        end else begin
            e.kind = K_RET;
            e.lat  = (opn == 1) ? 2 : 3;
        end
        return e;
    endfunction

    // Memory responder: raises mem_done on the cur_d-th cycle of an outstanding access.
    always @(negedge clk) begin
        if (!rst) begin
            mcnt = 0; mem_done = 1'b0;
        end else if (memread || memwrite) begin
            mcnt++;
            mem_done = (cur_d != 0) && (mcnt == cur_d);
        end else begin
            mcnt = 0; mem_done = 1'b0;
        end
    end

    // Monitor: pop and compare on every pc_en pulse and on halt/err rising.
    always @(negedge clk) begin : mon
        exp_t e;
        int   kind;
        cyc++;
        if (!rst) begin
            rd_cnt = 0; wr_cnt = 0; prev_halt = 1'b0; prev_err = 1'b0; acc_cyc = cyc;
        end else begin
            if (memread)  rd_cnt++;
            if (memwrite) wr_cnt++;
            kind = -1;
            if (pc_en)                  kind = K_RET;
            else if (halt && !prev_halt) kind = K_HALT;
            else if (err && !prev_err)   kind = K_ERR;
            if (regwrite) chk("regwrite_with_pc_en", int'(pc_en), 1);
            if (kind >= 0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_event: got event kind %0d, expected none (t=%0t)", kind, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("latency", cyc - acc_cyc, e.lat);
                    chk("memread_cycles", rd_cnt, e.rd);
                    chk("memwrite_cycles", wr_cnt, e.wr);
                    if (kind == K_RET) begin
                        chk("aluop", int'(aluop), e.aluop);
                        chk("regwrite", int'(regwrite), e.rw);
                        chk("busy_in_wb", int'(busy), 1);
                        chk("err_at_retire", int'(err), 0);
                    end
                end
            end
            if (instr_valid && instr_ready) begin
                acc_cyc = cyc; rd_cnt = 0; wr_cnt = 0;
            end
            prev_halt = halt;
            prev_err  = err;
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_instr_ready"}, int'(instr_ready), 1);
        chk({tag, "_aluop"}, int'(aluop), 0);
        chk({tag, "_outs"}, int'({regwrite, memread, memwrite, pc_en, halt, err, busy}), 0);
    endtask

    task automatic issue(input logic [4:0] op, input logic [1:0] f, input int d);
        int w = 0;
        while (!instr_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("instr_ready_wait", int'(instr_ready), 1);
        if (instr_ready) begin
            opcode = op; func = f; cur_d = d; instr_valid = 1'b1;
            exp_q.push_back(model(op, f, d));
            @(posedge clk); #1;
            instr_valid = 1'b0;
            opcode = 5'($urandom);
            func   = 2'($urandom);
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (exp_q.size() != 0 && w < 80) begin
            @(posedge clk); #1; w++;
        end
        chk("scoreboard_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0; #1;
        chk_reset_state("async_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_one(input logic [4:0] op, input logic [1:0] f, input int d);
        exp_t e;
        e = model(op, f, d);
        issue(op, f, d);
        wait_idle();
        if (e.kind == K_RET) begin
            chk("fetch_after_retire", int'({instr_ready, busy}), 2);
        end else if (e.kind == K_HALT) begin
            for (int i = 0; i < 20; i++) begin
                instr_valid = 1'($urandom); opcode = 5'($urandom);
                @(posedge clk); #1;
                chk("halt_sticky", int'({halt, pc_en, instr_ready, busy}), 8);
            end
            instr_valid = 1'b0;
            do_reset();
        end else begin
            for (int i = 0; i < 5; i++) begin
                instr_valid = 1'($urandom); opcode = 5'($urandom);
                @(posedge clk); #1;
                chk("err_sticky", int'({err, memread, memwrite, instr_ready, busy, halt}), 32);
            end
            instr_valid = 1'b0;
            do_reset();
        end
    endtask

    logic [4:0] pool [12] = '{5'b01000, 5'b10001, 5'b10000, 5'b10011, 5'b11011, 5'b11010,
                              5'b10101, 5'b01101, 5'b00100, 5'b00001, 5'b00000, 5'b11100};

    initial begin
        logic [4:0] op;
        int         d;
        // Reset held with an addi already presented; acceptance happens right after release.
        instr_valid = 1'b1; opcode = 5'b01000; func = 2'b00;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("por");
        rst = 1'b1;
        run_one(5'b01000, 2'b00, 0);
        run_one(5'b10001, 2'b00, 3);
        run_one(5'b10000, 2'b00, 3);
        run_one(5'b11011, 2'b10, 0);
        run_one(5'b10110, 2'($urandom), 0);
        run_one(5'b01100, 2'b00, 0);
        run_one(5'b10000, 2'b00, 0);
        run_one(5'b10000, 2'b00, TIMEOUT);
        run_one(5'b00000, 2'b00, 0);
        // Reset in the second MEM cycle of a load.
        issue(5'b10001, 2'b00, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mem2_memread", int'({memread, busy}), 3);
        #2 rst = 1'b0;
        #1;
        chk("midmem_rst", int'({memread, busy, instr_ready}), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_one(5'b01000, 2'b00, 0);
        run_one(5'b00001, 2'b00, 0);
        run_one(5'b10011, 2'b00, 1);
        run_one(5'b11010, 2'b01, 0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) op = pool[$urandom_range(0, 11)];
            else                           op = 5'($urandom);
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            run_one(op, 2'($urandom), d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
